// File: rtl/instr_encoder_if.sv
// Instruction-encoder load port: field handshake in, memory write strobe and status out.
interface instr_encoder_if #(
    parameter int unsigned ADDR_W = 6
);
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_kind;
    logic [3:0]        in_funct;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [12:0]       in_imm;
    logic              in_last;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [ADDR_W:0]   count;
    logic              done;
    logic              err;

    modport master (
        output start, in_valid, in_kind, in_funct, in_rd, in_rs1, in_rs2, in_imm, in_last,
        input  in_ready, mem_we, mem_addr, mem_wdata, count, done, err
    );

    modport slave (
        input  start, in_valid, in_kind, in_funct, in_rd, in_rs1, in_rs2, in_imm, in_last,
        output in_ready, mem_we, mem_addr, mem_wdata, count, done, err
    );
endinterface

// File: rtl/instr_encoder.sv
// Encodes lw/sw/R-type/beq fields into RV32I words and writes them sequentially
// into instruction memory, one word every two cycles.
module instr_encoder #(
    parameter int unsigned ADDR_W = 6
) (
    input  logic           clk,
    input  logic           rst,
    instr_encoder_if.slave bus
);

    typedef enum logic [1:0] {S_IDLE, S_ACCEPT, S_WRITE, S_DONE} state_e;
    typedef enum logic [1:0] {K_LW, K_SW, K_R, K_BEQ} kind_e;

    localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};

    state_e            state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              err_q, err_d;
    logic              last_q, last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;

    logic [31:0]       enc_word;
    logic              enc_legal;
    logic [ADDR_W:0]   count_inc;

    // Encode the presented fields and judge whether they fit the instruction format
    always_comb begin
        enc_word  = '0;
        enc_legal = 1'b1;
        unique case (kind_e'(bus.in_kind))
            K_LW: begin
                enc_word  = {bus.in_imm[11:0], bus.in_rs1, 3'b010, bus.in_rd, 7'b0000011};
                enc_legal = (bus.in_imm[12] == bus.in_imm[11]);
            end
            K_SW: begin
                enc_word  = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1, 3'b010,
                             bus.in_imm[4:0], 7'b0100011};
                enc_legal = (bus.in_imm[12] == bus.in_imm[11]);
            end
            K_R: begin
                enc_word  = {1'b0, bus.in_funct[3], 5'b00000, bus.in_rs2, bus.in_rs1,
                             bus.in_funct[2:0], bus.in_rd, 7'b0110011};
                enc_legal = 1'b1;
            end
            K_BEQ: begin
                enc_word  = {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2, bus.in_rs1, 3'b000,
                             bus.in_imm[4:1], bus.in_imm[11], 7'b1100011};
                enc_legal = ~bus.in_imm[0];
            end
            default: begin
                enc_word  = '0;
                enc_legal = 1'b0;
            end
        endcase
    end

    assign count_inc = count_q + {{ADDR_W{1'b0}}, 1'b1};

    // Next-state logic: accept fields, strobe the write, track count/error/completion
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        err_d   = err_q;
        last_d  = last_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d = S_ACCEPT;
                    count_d = '0;
                    err_d   = 1'b0;
                end
            end
            S_ACCEPT: begin
                if (bus.in_valid) begin
                    if (enc_legal) begin
                        state_d = S_WRITE;
                        wdata_d = enc_word;
                        addr_d  = count_q[ADDR_W-1:0];
                        last_d  = bus.in_last;
                    end else begin
                        // Rejected word is consumed without a write; a final word still ends the load
                        err_d = 1'b1;
                        if (bus.in_last) begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_WRITE: begin
                count_d = count_inc;
                if (last_q) begin
                    state_d = S_DONE;
                end else if (count_inc == FULL) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end else begin
                    state_d = S_ACCEPT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            count_q <= '0;
            err_q   <= 1'b0;
            last_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            err_q   <= err_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign bus.in_ready  = (state_q == S_ACCEPT);
    assign bus.mem_we    = (state_q == S_WRITE);
    assign bus.done      = (state_q == S_DONE);
    assign bus.err       = err_q;
    assign bus.count     = count_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized and directed bench for instr_encoder against a field-level reference model.
module tb_instr_encoder;

    localparam int unsigned AW    = 6;
    localparam int unsigned AWS   = 2;
    localparam int unsigned DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    instr_encoder_if #(.ADDR_W(AW))  mif ();
    instr_encoder_if #(.ADDR_W(AWS)) sif ();

    instr_encoder #(.ADDR_W(AW))  u_dut   (.clk(clk), .rst(rst), .bus(mif.slave));
    instr_encoder #(.ADDR_W(AWS)) u_small (.clk(clk), .rst(rst), .bus(sif.slave));

    int n_checks  = 0;
    int n_errors  = 0;
    int n_we_seen = 0;
    int n_we_exp  = 0;
    int s_we_seen = 0;

    // Reference model of the load in progress
    int unsigned m_count;
    bit          m_err;
    bit          m_done;
    logic [31:0] m_last_word;
    int unsigned m_last_addr;

    // Independent tally of write strobes, compared with the model at the end
    always @(negedge clk) begin
        if (mif.mem_we === 1'b1) n_we_seen++;
        if (sif.mem_we === 1'b1) s_we_seen++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // RV32I words built from the ISA field positions with shifts and masks
    function automatic logic [31:0] ref_word(input int unsigned kind, input int unsigned funct,
                                             input int unsigned rd, input int unsigned rs1,
                                             input int unsigned rs2, input int unsigned imm);
        int unsigned u;
        int unsigned w;
        u = imm & 32'h1FFF;
        case (kind)
            0: w = ((u & 32'hFFF) << 20) | (rs1 << 15) | (2 << 12) | (rd << 7) | 32'h03;
            1: w = (((u >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (2 << 12)
                   | ((u & 32'h1F) << 7) | 32'h23;
            2: w = ((funct >> 3) << 30) | (rs2 << 20) | (rs1 << 15) | ((funct & 7) << 12)
                   | (rd << 7) | 32'h33;
            default: w = (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3F) << 25) | (rs2 << 20)
                   | (rs1 << 15) | (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 1) << 7) | 32'h63;
        endcase
        return w;
    endfunction

    function automatic bit ref_legal(input int unsigned kind, input int unsigned imm);
        int s;
        s = (imm >= 4096) ? int'(imm) - 8192 : int'(imm);
        if (kind <= 1) return (s >= -2048) && (s <= 2047);
        if (kind == 3) return (imm % 2) == 0;
        return 1'b1;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start;
        mif.start = 1'b1;
        tick();
        mif.start = 1'b0;
        m_count = 0;
        m_err   = 1'b0;
        m_done  = 1'b0;
        check_eq("start_ready", 32'(mif.in_ready), 1);
        check_eq("start_count", 32'(mif.count), 0);
        check_eq("start_err", 32'(mif.err), 0);
        check_eq("start_done", 32'(mif.done), 0);
    endtask

    task automatic send(input int unsigned kind, input int unsigned funct, input int unsigned rd,
                        input int unsigned rs1, input int unsigned rs2, input int unsigned imm,
                        input bit last);
        int   waited;
        bit   legal;
        logic [31:0] w;
        waited = 0;
        while (mif.in_ready !== 1'b1 && waited < 8) begin
            tick();
            waited++;
        end
        if (mif.in_ready !== 1'b1) begin
            check_eq("ready_timeout", 32'(mif.in_ready), 1);
            return;
        end
        mif.in_kind  = 2'(kind);
        mif.in_funct = 4'(funct);
        mif.in_rd    = 5'(rd);
        mif.in_rs1   = 5'(rs1);
        mif.in_rs2   = 5'(rs2);
        mif.in_imm   = 13'(imm);
        mif.in_last  = last;
        mif.in_valid = 1'b1;
        tick();
        mif.in_valid = 1'b0;
        mif.in_last  = 1'b0;
        legal = ref_legal(kind, imm);
        w     = ref_word(kind, funct, rd, rs1, rs2, imm);
        if (legal) begin
            check_eq("wr_we", 32'(mif.mem_we), 1);
            check_eq("wr_addr", 32'(mif.mem_addr), m_count % DEPTH);
            check_eq("wr_data", mif.mem_wdata, w);
            check_eq("wr_count", 32'(mif.count), m_count);
            check_eq("wr_ready", 32'(mif.in_ready), 0);
            n_we_exp++;
            m_last_word = w;
            m_last_addr = m_count % DEPTH;
            tick();
            m_count++;
            if (last) begin
                m_done = 1'b1;
            end else if (m_count == DEPTH) begin
                m_done = 1'b1;
                m_err  = 1'b1;
            end
            check_eq("post_we", 32'(mif.mem_we), 0);
            check_eq("post_count", 32'(mif.count), m_count);
        end else begin
            m_err = 1'b1;
            if (last) m_done = 1'b1;
            check_eq("bad_we", 32'(mif.mem_we), 0);
            check_eq("bad_count", 32'(mif.count), m_count);
            check_eq("hold_data", mif.mem_wdata, m_last_word);
            check_eq("hold_addr", 32'(mif.mem_addr), m_last_addr);
        end
        check_eq("st_err", 32'(mif.err), 32'(m_err));
        check_eq("st_done", 32'(mif.done), 32'(m_done));
        check_eq("st_ready", 32'(mif.in_ready), 32'(!m_done));
    endtask

    initial begin
        int unsigned n, kind, imm, v;
        logic [31:0] sw_exp;

        rst = 1'b1;
        mif.start = 1'b0; mif.in_valid = 1'b0; mif.in_kind = '0; mif.in_funct = '0;
        mif.in_rd = '0; mif.in_rs1 = '0; mif.in_rs2 = '0; mif.in_imm = '0; mif.in_last = 1'b0;
        sif.start = 1'b0; sif.in_valid = 1'b0; sif.in_kind = '0; sif.in_funct = '0;
        sif.in_rd = '0; sif.in_rs1 = '0; sif.in_rs2 = '0; sif.in_imm = '0; sif.in_last = 1'b0;
        m_last_word = '0;
        m_last_addr = 0;
        tick();
        tick();
        rst = 1'b0;
        check_eq("rst_ready", 32'(mif.in_ready), 0);
        check_eq("rst_we", 32'(mif.mem_we), 0);
        check_eq("rst_done", 32'(mif.done), 0);
        check_eq("rst_err", 32'(mif.err), 0);
        check_eq("rst_addr", 32'(mif.mem_addr), 0);
        check_eq("rst_data", mif.mem_wdata, 0);
        check_eq("rst_count", 32'(mif.count), 0);
        tick();
        check_eq("idle_ready", 32'(mif.in_ready), 0);

        // Reference program from the decoder's own test list
        do_start();
        send(0, 0, 5, 2, 0, 8, 1'b0);
        check_eq("lw_const", m_last_word, 32'h00812283);
        send(1, 0, 0, 2, 6, 13'h1FFC, 1'b0);
        check_eq("sw_const", m_last_word, 32'hFE612E23);
        send(2, 4'b1000, 1, 3, 4, 0, 1'b0);
        check_eq("r_const", m_last_word, 32'h404180B3);
        send(3, 0, 0, 1, 2, 13'h1FF8, 1'b1);
        check_eq("beq_const", m_last_word, 32'hFE208CE3);

        // Out-of-range lw and odd branch offset are rejected
        do_start();
        send(0, 0, 1, 1, 0, 2048, 1'b0);
        send(3, 0, 0, 1, 2, 5, 1'b0);
        send(0, 0, 1, 1, 0, 13'h1800, 1'b1);

        // Random programs
        for (int ld = 0; ld < 25; ld++) begin
            do_start();
            n = $urandom_range(1, 8);
            for (int unsigned i = 0; i < n && !m_done; i++) begin
                kind = $urandom_range(0, 3);
                if ($urandom_range(0, 4) == 0) begin
                    imm = $urandom_range(0, 8191);
                end else begin
                    v   = $urandom_range(0, 1023) * 2;
                    imm = ($urandom_range(0, 1) == 1) ? ((8192 - v) & 8191) : v;
                end
                send(kind, $urandom_range(0, 15), $urandom_range(0, 31), $urandom_range(0, 31),
                     $urandom_range(0, 31), imm, i == n - 1);
            end
        end

        // Fill the whole memory without a final marker
        do_start();
        for (int unsigned i = 0; i < DEPTH; i++) begin
            send(0, 0, i % 32, 1, 0, (i * 4) & 2047, 1'b0);
        end
        check_eq("full_done", 32'(mif.done), 1);
        check_eq("full_err", 32'(mif.err), 1);
        check_eq("full_count", 32'(mif.count), DEPTH);

        // Small memory: fifth word must never be accepted
        sif.start = 1'b1;
        tick();
        sif.start = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            check_eq("s_ready", 32'(sif.in_ready), 1);
            sif.in_kind = 2'd0; sif.in_rd = 5'(i + 1); sif.in_rs1 = 5'd1; sif.in_imm = 13'(4 * i);
            sif.in_valid = 1'b1;
            tick();
            sif.in_valid = 1'b0;
            check_eq("s_we", 32'(sif.mem_we), 1);
            check_eq("s_addr", 32'(sif.mem_addr), i);
            check_eq("s_data", sif.mem_wdata, ref_word(0, 0, i + 1, 1, 0, 4 * i));
            tick();
        end
        check_eq("s_done", 32'(sif.done), 1);
        check_eq("s_err", 32'(sif.err), 1);
        check_eq("s_count", 32'(sif.count), 4);
        check_eq("s_full_ready", 32'(sif.in_ready), 0);
        sif.in_valid = 1'b1;
        repeat (3) tick();
        sif.in_valid = 1'b0;
        check_eq("s_we_total", 32'(s_we_seen), 4);

        // Reset during the write cycle aborts the load
        do_start();
        sw_exp = ref_word(0, 0, 7, 3, 0, 12);
        mif.in_kind = 2'd0; mif.in_rd = 5'd7; mif.in_rs1 = 5'd3; mif.in_imm = 13'd12;
        mif.in_valid = 1'b1;
        tick();
        mif.in_valid = 1'b0;
        check_eq("pre_rst_we", 32'(mif.mem_we), 1);
        check_eq("pre_rst_data", mif.mem_wdata, sw_exp);
        n_we_exp++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("arst_we", 32'(mif.mem_we), 0);
        check_eq("arst_ready", 32'(mif.in_ready), 0);
        check_eq("arst_done", 32'(mif.done), 0);
        check_eq("arst_err", 32'(mif.err), 0);
        check_eq("arst_addr", 32'(mif.mem_addr), 0);
        check_eq("arst_data", mif.mem_wdata, 0);
        check_eq("arst_count", 32'(mif.count), 0);
        m_last_word = '0;
        m_last_addr = 0;
        do_start();
        send(2, 4'b0000, 3, 4, 5, 0, 1'b1);
        check_eq("restart_addr", m_last_addr, 0);

        tick();
        check_eq("we_total", 32'(n_we_seen), 32'(n_we_exp));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
